// File: rtl/plot_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : plot_sequencer
//  Description : Front-panel controller for the plot display. Synchronises and
//                debounces the Next/Pre/Auto buttons, runs the auto-play dwell
//                timer, and commits plot changes only on frame_sync so the
//                picture never tears. Drives the one-hot plot enables.
//  Options     : SEQ_FRAME_TIMEOUT_EN - force the pending commit if frame_sync
//                does not arrive within FRAME_TIMEOUT cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module plot_sequencer #(
   parameter int NUM_PLOTS       = 4,
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int DWELL_CYCLES    = 268_435_456,
   parameter int FRAME_TIMEOUT   = 4_000_000,
   localparam int c_AW           = $clog2(NUM_PLOTS)
) (
   input  logic                 sysclk,
   input  logic                 rst_n,
   input  logic                 bt_next,
   input  logic                 bt_pre,
   input  logic                 bt_auto,
   input  logic                 frame_sync,
   output logic [NUM_PLOTS-1:0] enable_sw,
   output logic [c_AW-1:0]      plot_addr,
   output logic                 auto_on,
   output logic                 switch_busy
);

   localparam int               c_DBW        = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [c_DBW-1:0] c_DEB_LAST   = c_DBW'(DEBOUNCE_CYCLES - 1);
   localparam int               c_DWW        = $clog2(DWELL_CYCLES + 1);
   localparam logic [c_DWW-1:0] c_DWELL_LAST = c_DWW'(DWELL_CYCLES - 1);
   localparam logic [c_AW-1:0]  c_LAST_PLOT  = c_AW'(NUM_PLOTS - 1);

   typedef enum logic [0:0] {
      S_IDLE       = 1'b0,
      S_WAIT_FRAME = 1'b1
   } state_t;

   state_t                 r_state, w_state_nxt;
   logic [c_AW-1:0]        r_plot_addr, r_target, w_addr_nxt, w_target_nxt, w_step;
   logic [NUM_PLOTS-1:0]   r_enable_sw;
   logic                   r_auto_on, r_busy, w_commit, w_timeout, w_dwell_req;
   logic [c_DWW-1:0]       r_dwell_cnt;
   logic [2:0]             w_raw, w_press;
   logic                   w_next, w_pre, w_auto;

   // Modular step helpers; explicit compare so non-power-of-two counts wrap correctly
   function automatic logic [c_AW-1:0] f_inc(input logic [c_AW-1:0] v);
      return (v == c_LAST_PLOT) ? '0 : v + c_AW'(1);
   endfunction

   function automatic logic [c_AW-1:0] f_dec(input logic [c_AW-1:0] v);
      return (v == '0) ? c_LAST_PLOT : v - c_AW'(1);
   endfunction

   assign w_raw = {bt_auto, bt_pre, bt_next};

   for (genvar gi = 0; gi < 3; gi++) begin : g_btn
      logic             r_s1, r_s2, r_lvl, r_lvl_d, r_press;
      logic [c_DBW-1:0] r_cnt;
      // Two-flop synchroniser, debounce counter and registered rising-edge pulse
      always_ff @(posedge sysclk or negedge rst_n) begin
         if (!rst_n) begin
            r_s1    <= 1'b0;
            r_s2    <= 1'b0;
            r_lvl   <= 1'b0;
            r_lvl_d <= 1'b0;
            r_press <= 1'b0;
            r_cnt   <= '0;
         end else begin
            r_s1 <= w_raw[gi];
            r_s2 <= r_s1;
            if (r_s2 != r_lvl) begin
               if (r_cnt == c_DEB_LAST) begin
                  r_lvl <= r_s2;
                  r_cnt <= '0;
               end else begin
                  r_cnt <= r_cnt + c_DBW'(1);
               end
            end else begin
               r_cnt <= '0;
            end
            r_lvl_d <= r_lvl;
            r_press <= r_lvl & ~r_lvl_d;
         end
      end
      assign w_press[gi] = r_press;
   end

   // Next and Pre pressed together cancel each other
   assign w_next = w_press[0] & ~w_press[1];
   assign w_pre  = w_press[1] & ~w_press[0];
   assign w_auto = w_press[2];

   assign w_dwell_req = r_auto_on && (r_state == S_IDLE) && (r_dwell_cnt == c_DWELL_LAST);

`ifdef SEQ_FRAME_TIMEOUT_EN
   localparam int              c_TW      = $clog2(FRAME_TIMEOUT + 1);
   localparam logic [c_TW-1:0] c_TO_LAST = c_TW'(FRAME_TIMEOUT - 1);
   logic [c_TW-1:0]            r_to_cnt;

   // Stalled-display guard: count cycles spent waiting for frame_sync
   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n)
         r_to_cnt <= '0;
      else if ((r_state == S_WAIT_FRAME) && !w_commit)
         r_to_cnt <= r_to_cnt + c_TW'(1);
      else
         r_to_cnt <= '0;
   end

   assign w_timeout = (r_state == S_WAIT_FRAME) && (r_to_cnt == c_TO_LAST);
`else
   assign w_timeout = 1'b0;
`endif

   // Next-state logic: request capture in IDLE, target stepping and commit in WAIT_FRAME
   always_comb begin
      w_state_nxt  = r_state;
      w_target_nxt = r_target;
      w_addr_nxt   = r_plot_addr;
      w_commit     = 1'b0;
      w_step       = r_target;
      case (r_state)
         S_IDLE: begin
            // A manual press takes priority and drops any coincident dwell request
            if (w_pre) begin
               w_target_nxt = f_dec(r_plot_addr);
               w_state_nxt  = S_WAIT_FRAME;
            end else if (w_next || w_dwell_req) begin
               w_target_nxt = f_inc(r_plot_addr);
               w_state_nxt  = S_WAIT_FRAME;
            end
         end
         S_WAIT_FRAME: begin
            if (w_next)
               w_step = f_inc(r_target);
            else if (w_pre)
               w_step = f_dec(r_target);
            w_target_nxt = w_step;
            if (frame_sync || w_timeout) begin
               w_addr_nxt  = w_step;
               w_commit    = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // State, committed plot, one-hot enable decode and busy flag
   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_target    <= '0;
         r_plot_addr <= '0;
         r_enable_sw <= NUM_PLOTS'(1);
         r_busy      <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_target    <= w_target_nxt;
         r_plot_addr <= w_addr_nxt;
         r_enable_sw <= NUM_PLOTS'(1) << w_addr_nxt;
         r_busy      <= (w_state_nxt == S_WAIT_FRAME);
      end
   end

   // Auto-play toggle and dwell timer (frozen while a change is pending)
   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         r_auto_on   <= 1'b0;
         r_dwell_cnt <= '0;
      end else begin
         if (w_auto)
            r_auto_on <= ~r_auto_on;
         if (w_auto || w_commit)
            r_dwell_cnt <= '0;
         else if (r_auto_on && (r_state == S_IDLE))
            r_dwell_cnt <= (r_dwell_cnt == c_DWELL_LAST) ? '0 : r_dwell_cnt + c_DWW'(1);
      end
   end

   assign plot_addr   = r_plot_addr;
   assign enable_sw   = r_enable_sw;
   assign auto_on     = r_auto_on;
   assign switch_busy = r_busy;

endmodule
`default_nettype wire
